// File: rtl/gray_seq_checker.sv
// Gray-sequence monitor: decodes Gray samples, checks +1 steps, tracks lock, counts violations.
// Optional GRAY_STALL_ALLOW_EN: a repeated sample is a neutral stall instead of a violation.
module gray_seq_checker #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOCK_COUNT = 2,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 gray_valid,
    input  logic                 clear_err,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 locked,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

    state_t               r_state;
    logic [3:0]           r_good_cnt;
    logic                 r_prev_valid;
    logic [WIDTH-1:0]     r_bin_out;
    logic                 r_bin_valid;
    logic                 r_locked;
    logic                 r_step_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic [WIDTH-1:0]     w_bin;
    logic [WIDTH-1:0]     w_expect;
    logic [3:0]           w_good_next;
    logic                 w_legal;
    logic                 w_stall;
    logic                 w_check;
    logic                 w_err_inc;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_bin = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_bin[i] = ^(gray_in >> i);
        end
    end

    // r_bin_out doubles as the previous decoded sample.
    assign w_expect    = r_bin_out + 1'b1;
    assign w_good_next = r_good_cnt + 4'd1;
    assign w_legal     = (w_bin == w_expect);

`ifdef GRAY_STALL_ALLOW_EN
    assign w_stall = (w_bin == r_bin_out);
`else
    assign w_stall = 1'b0;
`endif

    assign w_check   = gray_valid && r_prev_valid && !w_stall;
    assign w_err_inc = w_check && !w_legal && (r_state == ST_LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_UNLOCKED;
            r_good_cnt   <= '0;
            r_prev_valid <= 1'b0;
            r_bin_out    <= '0;
            r_bin_valid  <= 1'b0;
            r_locked     <= 1'b0;
            r_step_err   <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_bin_valid <= 1'b0;
            r_step_err  <= 1'b0;

            if (clear_err) begin
                r_err_count <= '0;
            end else if (w_err_inc && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end

            if (gray_valid) begin
                r_bin_out    <= w_bin;
                r_bin_valid  <= 1'b1;
                r_prev_valid <= 1'b1;
            end

            if (w_check) begin
                case (r_state)
                    ST_UNLOCKED: begin
                        if (!w_legal) begin
                            r_good_cnt <= '0;
                        end else if (w_good_next >= LOCK_TARGET) begin
                            r_good_cnt <= '0;
                            r_state    <= ST_LOCKED;
                            r_locked   <= 1'b1;
                        end else begin
                            r_good_cnt <= w_good_next;
                        end
                    end
                    ST_LOCKED: begin
                        if (!w_legal) begin
                            r_step_err <= 1'b1;
                            r_good_cnt <= '0;
                            r_state    <= ST_UNLOCKED;
                            r_locked   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= ST_UNLOCKED;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bin_out   = r_bin_out;
    assign bin_valid = r_bin_valid;
    assign locked    = r_locked;
    assign step_err  = r_step_err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_gray_seq_checker.sv
// Bench for gray_seq_checker: directed plan steps then random traffic against a table-driven model.
module tb_gray_seq_checker;

    localparam int W    = 4;
    localparam int LC   = 2;
    localparam int EW   = 2;
    localparam int MODV = 1 << W;
    localparam int EMAX = (1 << EW) - 1;
`ifdef GRAY_STALL_ALLOW_EN
    localparam bit STALL_OK = 1'b1;
`else
    localparam bit STALL_OK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  gray_in;
    logic          gray_valid;
    logic          clear_err;
    logic [W-1:0]  bin_out;
    logic          bin_valid;
    logic          locked;
    logic          step_err;
    logic [EW-1:0] err_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: plain integers, decode by inverse table lookup.
    int g2b [MODV];
    int m_prev, m_pv, m_locked, m_good, m_err, m_bv, m_se;

    gray_seq_checker #(.WIDTH(W), .LOCK_COUNT(LC), .ERR_CNT_W(EW)) dut (
        .clk(clk), .rst(rst), .gray_in(gray_in), .gray_valid(gray_valid),
        .clear_err(clear_err), .bin_out(bin_out), .bin_valid(bin_valid),
        .locked(locked), .step_err(step_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_gray(input int b);
        return W'(b ^ (b >> 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".bin_out"},   32'(bin_out),   32'(m_prev));
        chk({tag, ".bin_valid"}, 32'(bin_valid), 32'(m_bv));
        chk({tag, ".step_err"},  32'(step_err),  32'(m_se));
        chk({tag, ".locked"},    32'(locked),    32'(m_locked));
        chk({tag, ".err_count"}, 32'(err_count), 32'(m_err));
    endtask

    task automatic model_reset();
        m_prev = 0; m_pv = 0; m_locked = 0; m_good = 0; m_err = 0; m_bv = 0; m_se = 0;
    endtask

    task automatic model_edge(input logic v, input logic [W-1:0] g, input logic clr);
        int b;
        bit inc;
        inc  = 1'b0;
        m_bv = 0;
        m_se = 0;
        if (v) begin
            b = g2b[g];
            if (m_pv != 0 && !(STALL_OK && b == m_prev)) begin
                if (m_locked != 0) begin
                    if (b != (m_prev + 1) % MODV) begin
                        m_se = 1; inc = 1'b1; m_locked = 0; m_good = 0;
                    end
                end else if (b == (m_prev + 1) % MODV) begin
                    m_good++;
                    if (m_good >= LC) begin m_locked = 1; m_good = 0; end
                end else begin
                    m_good = 0;
                end
            end
            m_prev = b;
            m_pv   = 1;
            m_bv   = 1;
        end
        if (clr) m_err = 0;
        else if (inc && m_err < EMAX) m_err++;
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic step(input logic v, input logic [W-1:0] g, input logic clr, input string tag);
        gray_valid = v; gray_in = g; clear_err = clr;
        @(posedge clk);
        model_edge(v, g, clr);
        @(negedge clk);
        gray_valid = 1'b0; clear_err = 1'b0;
        check_all(tag);
    endtask

    // Relock from the current model value, then skip one code while locked.
    task automatic relock_and_violate(input logic clr, input string tag);
        step(1'b1, to_gray((m_prev + 1) % MODV), 1'b0, {tag, ".r1"});
        step(1'b1, to_gray((m_prev + 1) % MODV), 1'b0, {tag, ".r2"});
        chk({tag, ".locked_before"}, 32'(locked), 32'd1);
        step(1'b1, to_gray((m_prev + 2) % MODV), clr, {tag, ".viol"});
        chk({tag, ".step_err"}, 32'(step_err), 32'd1);
    endtask

    initial begin
        int r, nb;
        logic v, clr;
        for (int i = 0; i < MODV; i++) g2b[to_gray(i)] = i;

        rst = 1'b1; gray_in = '0; gray_valid = 1'b0; clear_err = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        @(negedge clk);

        step(1'b1, 4'b0000, 1'b0, "basic0");
        step(1'b1, 4'b0001, 1'b0, "basic1");
        step(1'b0, 4'b1111, 1'b0, "gap");
        step(1'b1, 4'b0011, 1'b0, "basic2");
        chk("basic.bin2", 32'(bin_out), 32'd2);
        chk("basic.lock", 32'(locked), 32'd1);

        step(1'b1, 4'b0011, 1'b0, "stall");
        chk("stall.err", 32'(err_count), STALL_OK ? 32'd0 : 32'd1);
        step(1'b1, 4'b0010, 1'b0, "post_stall3");
        step(1'b1, 4'b0110, 1'b0, "seq4");
        step(1'b1, 4'b0111, 1'b0, "seq5");
        chk("skip.pre_lock", 32'(locked), 32'd1);
        step(1'b1, 4'b0100, 1'b0, "skip");
        chk("skip.step_err", 32'(step_err), 32'd1);
        chk("skip.unlocked", 32'(locked), 32'd0);
        step(1'b1, 4'b1100, 1'b0, "relock8");
        step(1'b1, 4'b1101, 1'b0, "relock9");
        chk("relock.locked", 32'(locked), 32'd1);

        step(1'b1, 4'b1111, 1'b0, "seq10");
        step(1'b1, 4'b1110, 1'b0, "seq11");
        step(1'b1, 4'b1010, 1'b0, "seq12");
        step(1'b1, 4'b1011, 1'b0, "seq13");
        step(1'b1, 4'b1001, 1'b0, "seq14");
        step(1'b1, 4'b1000, 1'b0, "seq15");
        step(1'b1, 4'b0000, 1'b0, "wrap");
        chk("wrap.bin0", 32'(bin_out), 32'd0);
        chk("wrap.locked", 32'(locked), 32'd1);

        for (int k = 0; k < 4; k++) relock_and_violate(1'b0, $sformatf("sat%0d", k));
        chk("sat.count", 32'(err_count), 32'(EMAX));
        step(1'b0, 4'b0000, 1'b1, "clear");
        chk("clear.count", 32'(err_count), 32'd0);
        relock_and_violate(1'b1, "clr_vs_inc");
        chk("clr_vs_inc.count", 32'(err_count), 32'd0);

        relock_and_violate(1'b0, "pre_rst_a");
        relock_and_violate(1'b0, "pre_rst_b");
        step(1'b1, to_gray((m_prev + 1) % MODV), 1'b0, "pre_rst_r1");
        step(1'b1, to_gray((m_prev + 1) % MODV), 1'b0, "pre_rst_r2");
        chk("pre_rst.locked", 32'(locked), 32'd1);
        chk("pre_rst.err", 32'(err_count), 32'd2);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst.locked", 32'(locked), 32'd0);
        chk("arst.err", 32'(err_count), 32'd0);
        chk("arst.bin_out", 32'(bin_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_all("arst_hold");
        step(1'b1, 4'b0101, 1'b0, "seed_after_rst");
        step(1'b1, 4'b0111, 1'b0, "after_rst2");

        // Mostly-legal random traffic with repeats, skips, gaps and clears.
        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 4) != 0);
            clr = ($urandom_range(0, 29) == 0);
            r   = $urandom_range(0, 9);
            if (r < 7)      nb = (m_prev + 1) % MODV;
            else if (r < 8) nb = m_prev;
            else            nb = $urandom_range(0, MODV - 1);
            step(v, to_gray(nb), clr, $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
